// File: rtl/mb_txn_ctrl.sv
// Multibanco withdrawal transaction controller.
// Card/PIN/amount checks, dispenser handshake, balance write-back.
module mb_txn_ctrl #(
    parameter int MAX_TRIES = 3,
    parameter int TIMEOUT   = 200
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CARD,
    input  logic [5:0] COD,
    input  logic [4:0] SALDO,
    input  logic [4:0] PIN,
    input  logic       PIN_VALID,
    input  logic [4:0] VAL,
    input  logic       VAL_VALID,
    input  logic       CANCEL,
    input  logic       DISP_ACK,
    output logic       DISP_REQ,
    output logic [4:0] VAL_OUT,
    output logic [4:0] SALDO_OUT,
    output logic       SALDO_WE,
    output logic [5:0] ECRA,
    output logic       PAR,
    output logic       EJECT,
    output logic       CAPT,
    output logic [2:0] STATE
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PIN   = 3'd1;
    localparam logic [2:0] S_VAL   = 3'd2;
    localparam logic [2:0] S_DISP  = 3'd3;
    localparam logic [2:0] S_EJECT = 3'd4;
    localparam logic [2:0] S_CAPT  = 3'd5;

    localparam logic [2:0] TRIES0 = 3'(MAX_TRIES);
    localparam logic [7:0] TMO    = 8'(TIMEOUT);

    logic [2:0] r_state;
    logic [4:0] r_bal;
    logic [5:0] r_codr;
    logic [2:0] r_tries;
    logic [7:0] r_tmo;
    logic       r_hold;
    logic       r_disp_req;
    logic [4:0] r_val_out;
    logic [4:0] r_saldo_out;
    logic       r_saldo_we;
    logic [5:0] r_ecra;
    logic       r_par;
    logic       r_eject;
    logic       r_capt;

    logic [2:0] w_state;
    logic [4:0] w_bal;
    logic [5:0] w_codr;
    logic [2:0] w_tries;
    logic [7:0] w_tmo;
    logic       w_hold;
    logic       w_disp_req;
    logic [4:0] w_val_out;
    logic [4:0] w_saldo_out;
    logic       w_saldo_we;
    logic [5:0] w_ecra;
    logic       w_eject;
    logic       w_capt;

    logic [2:0] w_tries_dec;
    logic [4:0] w_bal_new;
    logic       w_tmo_hit;
    logic       w_strobe;
    logic       w_pin_ok;
    logic       w_val_bad;

    assign w_tries_dec = r_tries - 3'd1;
    assign w_bal_new   = r_bal - r_val_out;
    assign w_tmo_hit   = (r_tmo == TMO);
    assign w_strobe    = PIN_VALID | VAL_VALID;
    assign w_pin_ok    = ({1'b0, PIN} == r_codr);
    assign w_val_bad   = (VAL == 5'd0) || (VAL > r_bal);

    // Next-state and next-output decode for the transaction sequence
    always_comb begin
        w_state     = r_state;
        w_bal       = r_bal;
        w_codr      = r_codr;
        w_tries     = r_tries;
        w_tmo       = 8'd0;
        w_hold      = r_hold;
        w_disp_req  = r_disp_req;
        w_val_out   = r_val_out;
        w_saldo_out = r_saldo_out;
        w_saldo_we  = 1'b0;
        w_ecra      = r_ecra;
        w_eject     = r_eject;
        w_capt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!CARD) begin
                    w_hold = 1'b0;
                end else if (!r_hold) begin
                    w_bal   = SALDO;
                    w_codr  = COD;
                    w_tries = TRIES0;
                    w_ecra  = 6'd0;
                    w_state = S_PIN;
                end
            end
            S_PIN, S_VAL: begin
                if (!CARD) begin
                    w_state = S_IDLE;
                end else if (CANCEL || w_tmo_hit) begin
                    w_state = S_EJECT;
                    w_eject = 1'b1;
                end else if (r_state == S_PIN) begin
                    if (PIN_VALID && w_pin_ok) begin
                        w_ecra  = {1'b0, r_bal};
                        w_state = S_VAL;
                    end else if (PIN_VALID) begin
                        w_tries = w_tries_dec;
                        if (w_tries_dec == 3'd0) begin
                            w_state = S_CAPT;
                            w_capt  = 1'b1;
                            w_ecra  = 6'h3F;
                        end else begin
                            w_ecra = {3'd0, w_tries_dec};
                        end
                    end
                end else if (VAL_VALID) begin
                    if (w_val_bad) begin
                        w_ecra = 6'h3E;
                    end else begin
                        w_val_out  = VAL;
                        w_disp_req = 1'b1;
                        w_state    = S_DISP;
                    end
                end
                if (w_state == r_state && !w_strobe)
                    w_tmo = r_tmo + 8'd1;
            end
            S_DISP: begin
                if (DISP_ACK) begin
                    w_disp_req  = 1'b0;
                    w_bal       = w_bal_new;
                    w_saldo_out = w_bal_new;
                    w_saldo_we  = 1'b1;
                    w_ecra      = {1'b0, w_bal_new};
                    w_eject     = CARD;
                    w_state     = S_EJECT;
                end
            end
            S_EJECT: begin
                if (!CARD) begin
                    w_eject = 1'b0;
                    w_ecra  = 6'd0;
                    w_state = S_IDLE;
                end else begin
                    w_eject = 1'b1;
                end
            end
            S_CAPT: begin
                w_hold  = 1'b1;
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_bal       <= 5'd0;
            r_codr      <= 6'd0;
            r_tries     <= TRIES0;
            r_tmo       <= 8'd0;
            r_hold      <= 1'b0;
            r_disp_req  <= 1'b0;
            r_val_out   <= 5'd0;
            r_saldo_out <= 5'd0;
            r_saldo_we  <= 1'b0;
            r_ecra      <= 6'd0;
            r_par       <= 1'b0;
            r_eject     <= 1'b0;
            r_capt      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_bal       <= w_bal;
            r_codr      <= w_codr;
            r_tries     <= w_tries;
            r_tmo       <= w_tmo;
            r_hold      <= w_hold;
            r_disp_req  <= w_disp_req;
            r_val_out   <= w_val_out;
            r_saldo_out <= w_saldo_out;
            r_saldo_we  <= w_saldo_we;
            r_ecra      <= w_ecra;
            r_par       <= ^w_ecra;
            r_eject     <= w_eject;
            r_capt      <= w_capt;
        end
    end

    assign DISP_REQ  = r_disp_req;
    assign VAL_OUT   = r_val_out;
    assign SALDO_OUT = r_saldo_out;
    assign SALDO_WE  = r_saldo_we;
    assign ECRA      = r_ecra;
    assign PAR       = r_par;
    assign EJECT     = r_eject;
    assign CAPT      = r_capt;
    assign STATE     = r_state;

endmodule

// File: tb/tb_mb_txn_ctrl.sv
// Testbench for mb_txn_ctrl: directed scenarios plus random
// sessions against a behavioural session model.
module tb_mb_txn_ctrl;

    localparam int MAXT = 3;
    localparam int TMO  = 200;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       card = 1'b0;
    logic [5:0] cod = '0;
    logic [4:0] saldo = '0;
    logic [4:0] pin = '0;
    logic       pin_v = 1'b0;
    logic [4:0] val = '0;
    logic       val_v = 1'b0;
    logic       cancel = 1'b0;
    logic       ack = 1'b0;

    logic       o_req;
    logic [4:0] o_vo;
    logic [4:0] o_so;
    logic       o_we;
    logic [5:0] o_ecra;
    logic       o_par;
    logic       o_ej;
    logic       o_capt;
    logic [2:0] o_st;

    int errs = 0;
    int nchk = 0;

    // session model: phase, stored card data, expected outputs
    int m_st, m_bal, m_cod, m_tries, m_tmo, m_hold;
    int e_req, e_vo, e_so, e_we, e_ecra, e_ej, e_capt;

    mb_txn_ctrl #(.MAX_TRIES(MAXT), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST_N(RST_N), .CARD(card), .COD(cod),
        .SALDO(saldo), .PIN(pin), .PIN_VALID(pin_v), .VAL(val),
        .VAL_VALID(val_v), .CANCEL(cancel), .DISP_ACK(ack),
        .DISP_REQ(o_req), .VAL_OUT(o_vo), .SALDO_OUT(o_so),
        .SALDO_WE(o_we), .ECRA(o_ecra), .PAR(o_par), .EJECT(o_ej),
        .CAPT(o_capt), .STATE(o_st)
    );

    always #5 CLK = ~CLK;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ref_reset();
        m_st = 0; m_bal = 0; m_cod = 0; m_tries = MAXT;
        m_tmo = 0; m_hold = 0;
        e_req = 0; e_vo = 0; e_so = 0; e_we = 0;
        e_ecra = 0; e_ej = 0; e_capt = 0;
    endtask

    // one clock of the withdrawal session, from the rules
    task automatic ref_step();
        int nx;
        nx = m_st;
        e_we = 0;
        e_capt = 0;
        if (m_st == 0) begin
            if (!card) m_hold = 0;
            else if (m_hold == 0) begin
                m_bal = saldo; m_cod = cod; m_tries = MAXT;
                e_ecra = 0; nx = 1;
            end
        end else if (m_st == 1 || m_st == 2) begin
            if (!card) nx = 0;
            else if (cancel || m_tmo == TMO) begin
                nx = 4; e_ej = 1;
            end else if (m_st == 1 && pin_v) begin
                if (int'(pin) == m_cod) begin
                    e_ecra = m_bal; nx = 2;
                end else begin
                    m_tries = m_tries - 1;
                    if (m_tries == 0) begin
                        nx = 5; e_capt = 1; e_ecra = 63;
                    end else e_ecra = m_tries;
                end
            end else if (m_st == 2 && val_v) begin
                if (val == 0 || int'(val) > m_bal) e_ecra = 62;
                else begin
                    e_vo = val; e_req = 1; nx = 3;
                end
            end
        end else if (m_st == 3) begin
            if (ack) begin
                m_bal = m_bal - e_vo;
                e_req = 0; e_so = m_bal; e_we = 1;
                e_ecra = m_bal; e_ej = card; nx = 4;
            end
        end else if (m_st == 4) begin
            if (!card) begin
                e_ej = 0; e_ecra = 0; nx = 0;
            end else e_ej = 1;
        end else begin
            m_hold = 1; nx = 0;
        end
        if ((m_st == 1 || m_st == 2) && nx == m_st && !(pin_v || val_v))
            m_tmo = m_tmo + 1;
        else
            m_tmo = 0;
        m_st = nx;
    endtask

    task automatic check_all();
        chk("STATE", o_st, m_st);
        chk("ECRA", o_ecra, e_ecra);
        chk("PAR", o_par, $countones(e_ecra) % 2);
        chk("DISP_REQ", o_req, e_req);
        chk("VAL_OUT", o_vo, e_vo);
        chk("SALDO_OUT", o_so, e_so);
        chk("SALDO_WE", o_we, e_we);
        chk("EJECT", o_ej, e_ej);
        chk("CAPT", o_capt, e_capt);
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RST_N) ref_step();
        else ref_reset();
        #1;
        check_all();
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_pin(logic [4:0] p);
        pin = p; pin_v = 1'b1; tick(); pin_v = 1'b0;
    endtask

    task automatic do_val(logic [4:0] v);
        val = v; val_v = 1'b1; tick(); val_v = 1'b0;
    endtask

    task automatic start(logic [5:0] c, logic [4:0] s);
        card = 1'b1; cod = c; saldo = s; tick();
    endtask

    task automatic leave();
        card = 1'b0; ticks(2);
    endtask

    initial begin
        ref_reset();
        ticks(2);
        chk("rst_state", o_st, 0);
        chk("rst_ecra", o_ecra, 0);
        RST_N = 1'b1;
        tick();

        // happy path
        start(6'd9, 5'd20);
        tick();
        do_pin(5'd9);
        chk("hp_ecra_bal", o_ecra, 20);
        do_val(5'd7);
        chk("hp_req", o_req, 1);
        chk("hp_vo", o_vo, 7);
        ticks(2);
        chk("hp_vo_held", o_vo, 7);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("hp_we", o_we, 1);
        chk("hp_so", o_so, 13);
        chk("hp_ecra", o_ecra, 13);
        chk("hp_par", o_par, 1);
        tick();
        chk("hp_we_once", o_we, 0);
        chk("hp_eject", o_ej, 1);
        leave();
        chk("hp_idle", o_st, 0);

        // wrong PIN three times
        start(6'd9, 5'd20);
        do_pin(5'd3);
        chk("wp_ecra2", o_ecra, 2);
        do_pin(5'd3);
        chk("wp_ecra1", o_ecra, 1);
        do_pin(5'd3);
        chk("wp_capt", o_capt, 1);
        chk("wp_ecra3f", o_ecra, 63);
        ticks(4);
        chk("wp_no_restart", o_st, 0);
        chk("wp_capt_once", o_capt, 0);
        leave();

        // amount checks
        start(6'd4, 5'd5);
        do_pin(5'd4);
        do_val(5'd6);
        chk("am_big", o_ecra, 62);
        chk("am_stay", o_st, 2);
        do_val(5'd0);
        chk("am_zero", o_ecra, 62);
        do_val(5'd5);
        chk("am_disp", o_st, 3);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("am_so", o_so, 0);
        leave();

        // timeout in PIN_WAIT
        start(6'd1, 5'd9);
        ticks(TMO + 1);
        chk("to_state", o_st, 4);
        chk("to_eject", o_ej, 1);
        leave();

        // cancel with VAL_VALID
        start(6'd2, 5'd9);
        do_pin(5'd2);
        cancel = 1'b1; do_val(5'd3); cancel = 1'b0;
        chk("cn_state", o_st, 4);
        chk("cn_req", o_req, 0);
        leave();

        // committed transaction ignores CANCEL / CARD=0
        start(6'd2, 5'd9);
        do_pin(5'd2);
        do_val(5'd4);
        cancel = 1'b1; card = 1'b0;
        ticks(2);
        chk("cm_req", o_req, 1);
        ack = 1'b1; tick(); ack = 1'b0; cancel = 1'b0;
        chk("cm_we", o_we, 1);
        chk("cm_so", o_so, 5);
        tick();
        chk("cm_we_once", o_we, 0);
        tick();

        // reset during DISPENSE
        start(6'd2, 5'd9);
        do_pin(5'd2);
        do_val(5'd4);
        #2 RST_N = 1'b0;
        #1;
        ref_reset();
        check_all();
        chk("rd_req", o_req, 0);
        ack = 1'b1;
        ticks(2);
        #2 RST_N = 1'b1;
        ack = 1'b0; card = 1'b0;
        ticks(3);

        // random sessions
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) card = ~card;
            cod = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                                              : 6'($urandom_range(0, 31));
            saldo  = 5'($urandom);
            pin    = $urandom_range(0, 1) ? cod[4:0] : 5'($urandom);
            pin_v  = ($urandom_range(0, 3) == 0);
            val    = 5'($urandom_range(0, 31));
            val_v  = ($urandom_range(0, 3) == 0);
            cancel = ($urandom_range(0, 40) == 0);
            ack    = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
